imem_loader: RTL and testbench

IMEM_LOADER -- requirements
Module: imem_loader

---
 rtl/imem_loader.sv | 125 ++++++++++++
 tb/tb_imem_loader.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/imem_loader.sv
// Streams a length-prefixed, big-endian word image into instruction memory and holds the core in reset until it is loaded.
// Optional trailer checksum verification: define IMEM_LOADER_CHECKSUM_EN.
module imem_loader #(
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    input  logic [7:0]        in_byte,
    output logic              in_ready,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic              cpu_reset,
    output logic              done,
    output logic              error
);

    typedef enum logic [2:0] {HDR, DATA, CSUM, RUN, ERR} state_t;

    localparam logic [16:0] MAX_WORDS = 17'(1) << ADDR_W;

    state_t      state, state_nxt;
    logic        live;      // low until the first edge after reset release
    logic [1:0]  bcnt;
    logic [16:0] n_words;
    logic [16:0] widx;
    logic [23:0] shreg;
`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [31:0] csum_acc;
`endif

    logic        take;
    logic [31:0] word_full;
    logic [15:0] hdr;
    logic        last_word;

    assign take      = in_valid & in_ready;
    assign word_full = {shreg, in_byte};
    assign hdr       = {shreg[7:0], in_byte};
    assign last_word = (widx + 17'd1) == n_words;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= HDR;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        cpu_reset = 1'b1;
        done      = 1'b0;
        error     = 1'b0;
        case (state)
            HDR: begin
                in_ready = live;
                if (take && bcnt == 2'd1) begin
                    if ({1'b0, hdr} > MAX_WORDS) state_nxt = ERR;
                    else if (hdr != 16'd0)       state_nxt = DATA;
                    else                         state_nxt = CSUM;
                end
            end
            DATA: begin
                in_ready = 1'b1;
                if (take && bcnt == 2'd3 && last_word) state_nxt = CSUM;
            end
            CSUM: begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                in_ready = 1'b1;
                if (take && bcnt == 2'd3)
                    state_nxt = (word_full == csum_acc) ? RUN : ERR;
`else
                // no trailer is consumed; one cycle here keeps cpu_reset high past the last write
                state_nxt = RUN;
`endif
            end
            RUN: begin
                cpu_reset = 1'b0;
                done      = 1'b1;
            end
            ERR: error = 1'b1;
            default: state_nxt = HDR;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            live       <= 1'b0;
            bcnt       <= 2'd0;
            n_words    <= 17'd0;
            widx       <= 17'd0;
            shreg      <= 24'd0;
            imem_we    <= 1'b0;
            imem_addr  <= '0;
            imem_wdata <= 32'd0;
`ifdef IMEM_LOADER_CHECKSUM_EN
            csum_acc   <= 32'd0;
`endif
        end else begin
            live    <= 1'b1;
            imem_we <= 1'b0;
            if (take) begin
                shreg <= word_full[23:0];
                bcnt  <= bcnt + 2'd1;
                case (state)
                    HDR: if (bcnt == 2'd1) begin
                        n_words <= {1'b0, hdr};
                        bcnt    <= 2'd0;
                    end
                    DATA: if (bcnt == 2'd3) begin
                        imem_we    <= 1'b1;
                        imem_wdata <= word_full;
                        imem_addr  <= widx[ADDR_W-1:0];
                        widx       <= widx + 17'd1;
`ifdef IMEM_LOADER_CHECKSUM_EN
                        csum_acc   <= csum_acc + word_full;
`endif
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// Randomized + directed bench for imem_loader against a stream-level reference model.
module tb_imem_loader;
    localparam int ADDR_W = 8;

    logic              clk = 1'b0;
    logic              reset = 1'b0;
    logic              in_valid = 1'b0;
    logic [7:0]        in_byte = 8'd0;
    logic              in_ready, imem_we, cpu_reset, done, error;
    logic [ADDR_W-1:0] imem_addr;
    logic [31:0]       imem_wdata;

    imem_loader #(.ADDR_W(ADDR_W)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_byte(in_byte),
        .in_ready(in_ready), .imem_we(imem_we), .imem_addr(imem_addr),
        .imem_wdata(imem_wdata), .cpu_reset(cpu_reset), .done(done), .error(error)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int fails  = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    logic [7:0]         stim[$];
    logic [31:0]        wq[$];
    logic [ADDR_W+31:0] got_w[$];
    logic [ADDR_W+31:0] exp_w[$];
    int                 exp_cons;
    bit                 exp_done;
    int                 order_bad = 0;

    // capture every write; the core must still be held in reset while writes happen
    always @(negedge clk) begin
        if (reset && imem_we) begin
            got_w.push_back({imem_addr, imem_wdata});
            if (!cpu_reset) order_bad++;
        end
    end

    function automatic logic [31:0] sum_wq();
        logic [31:0] s = 32'd0;
        foreach (wq[i]) s += wq[i];
        return s;
    endfunction

    task automatic build(input int hdr, input logic [31:0] ck);
        stim.delete();
        stim.push_back(8'(hdr >> 8));
        stim.push_back(8'(hdr));
        foreach (wq[i]) for (int b = 3; b >= 0; b--) stim.push_back(8'(wq[i] >> (8 * b)));
        for (int b = 3; b >= 0; b--) stim.push_back(8'(ck >> (8 * b)));
    endtask

    // reference: interpret the byte stream directly from the format rules
    task automatic model();
        int n;
        logic [31:0] s, w, ck;
        logic [ADDR_W-1:0] a;
        exp_w.delete();
        n = (int'(stim[0]) << 8) | int'(stim[1]);
        if (n > (1 << ADDR_W)) begin
            exp_cons = 2;
            exp_done = 1'b0;
            return;
        end
        s = 32'd0;
        for (int i = 0; i < n; i++) begin
            w = {stim[2+4*i], stim[3+4*i], stim[4+4*i], stim[5+4*i]};
            s += w;
            a = ADDR_W'(i);
            exp_w.push_back({a, w});
        end
`ifdef IMEM_LOADER_CHECKSUM_EN
        ck = {stim[2+4*n], stim[3+4*n], stim[4+4*n], stim[5+4*n]};
        exp_cons = 2 + 4 * n + 4;
        exp_done = (ck == s);
`else
        ck = 32'd0;
        exp_cons = 2 + 4 * n;
        exp_done = 1'b1;
`endif
    endtask

    task automatic do_reset();
        in_valid = 1'b0;
        reset    = 1'b0;
        #1;
        chk("rst_we",    imem_we, 0);
        chk("rst_ready", in_ready, 0);
        chk("rst_cpu",   cpu_reset, 1);
        chk("rst_done",  done, 0);
        chk("rst_err",   error, 0);
        chk("rst_addr",  imem_addr, 0);
        chk("rst_wdata", imem_wdata, 0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        reset = 1'b1;
        got_w.delete();
        order_bad = 0;
    endtask

    // mode 0: valid held, 1: valid every other cycle, 2: random gaps
    task automatic drive(input int lim, input int mode, output int acc);
        int stall = 0;
        int cyc = 0;
        bit want, go;
        acc = 0;
        while (acc < lim && stall < 8) begin
            want = (mode == 0) ? 1'b1 : (mode == 1) ? (cyc % 2 == 0) : ($urandom_range(0, 1) == 1);
            go = want && in_ready;
            in_valid = go;
            in_byte  = go ? stim[acc] : 8'($urandom);
            stall = in_ready ? 0 : stall + 1;
            @(posedge clk); #1;
            if (go) acc++;
            cyc++;
        end
        in_valid = 1'b0;
    endtask

    task automatic check_run(input string tag, input int acc);
        int n;
        repeat (3) @(posedge clk);
        #1;
        chk({tag, "/consumed"}, acc, exp_cons);
        chk({tag, "/nwrites"}, got_w.size(), exp_w.size());
        n = (got_w.size() < exp_w.size()) ? got_w.size() : exp_w.size();
        for (int i = 0; i < n; i++) chk({tag, "/write"}, got_w[i], exp_w[i]);
        chk({tag, "/done"},      done, exp_done);
        chk({tag, "/error"},     error, !exp_done);
        chk({tag, "/cpu_reset"}, cpu_reset, !exp_done);
        chk({tag, "/in_ready"},  in_ready, 0);
        chk({tag, "/we_order"},  order_bad, 0);
    endtask

    task automatic run_case(input string tag, input int mode);
        int acc;
        do_reset();
        model();
        drive(stim.size(), mode, acc);
        check_run(tag, acc);
    endtask

    initial begin
        int acc, n;
        // good checksum, valid held
        wq = '{32'h012A8020, 32'hAE100010};
        build(2, 32'hAF3A8030);
        run_case("n2_good", 0);
        // bad checksum
        build(2, 32'h0);
        run_case("n2_badck", 0);
        // oversized header
        wq.delete();
        build(16'h0101, 32'h0);
        run_case("oversize", 0);
        // single word, valid toggling
        wq = '{32'h8E110010};
        build(1, 32'h8E110010);
        run_case("n1_toggle", 1);
        // empty image
        wq.delete();
        build(0, 32'h0);
        run_case("n0", 0);
        // abort mid-load, then a fresh stream
        wq = '{32'h11223344, 32'h55667788};
        build(2, sum_wq());
        do_reset();
        drive(5, 0, acc);
        wq = '{32'hCAFEF00D};
        build(1, sum_wq());
        do_reset();
        model();
        drive(stim.size(), 0, acc);
        check_run("abort", acc);
        // full-depth image
        wq.delete();
        for (int i = 0; i < (1 << ADDR_W); i++) wq.push_back($urandom);
        build(1 << ADDR_W, sum_wq());
        run_case("full", 2);
        // one past full depth
        build((1 << ADDR_W) + 1, 32'h0);
        run_case("over1", 0);
        // random streams
        for (int t = 0; t < 20; t++) begin
            wq.delete();
            n = $urandom_range(0, 6);
            for (int i = 0; i < n; i++) wq.push_back($urandom);
            if ($urandom_range(0, 9) == 0) build($urandom_range(257, 65535), 32'h0);
            else build(n, ($urandom_range(0, 1) == 1) ? sum_wq() : 32'($urandom));
            run_case("rand", $urandom_range(0, 2));
        end
        $display("[TB] %0d tests run, %0d failed", checks, fails);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end
endmodule
